// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD controller.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD
   } state_t;

   // Field positions inside the 32-bit LCD register word
   localparam int unsigned WORD_W   = 32;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned DATA_LSB = 0;
   localparam int unsigned RS_BIT   = 8;
   localparam int unsigned ON_BIT   = 31;

   // Power-up initialisation sequence
   localparam int unsigned INIT_N        = 4;
   localparam logic [7:0]  CMD_FUNC_SET  = 8'h38;
   localparam logic [7:0]  CMD_DISP_ON   = 8'h0C;
   localparam logic [7:0]  CMD_CLEAR     = 8'h01;
   localparam logic [7:0]  CMD_ENTRY     = 8'h06;

   // Commands needing the long execution wait (clear / return home)
   localparam logic [7:0]  CLR_MIN = 8'h01;
   localparam logic [7:0]  CLR_MAX = 8'h03;

   // Command issued at a given step of the initialisation sequence
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return CMD_FUNC_SET;
         2'd1:    return CMD_DISP_ON;
         2'd2:    return CMD_CLEAR;
         default: return CMD_ENTRY;
      endcase
   endfunction

   // True for instruction writes that take the long execution time
   function automatic logic is_clear(input logic rs, input logic [7:0] data);
      return !rs && (data >= CLR_MIN) && (data <= CLR_MAX);
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done_c flags a count of zero so a phase loaded with N-1 lasts N cycles.
module lcd_timer #(
   parameter int unsigned CNT_W = 20
) (
   input  logic             clk,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done_c
);

   logic [CNT_W-1:0] cnt;

   // Load has priority; otherwise count down and park at zero
   always_ff @(posedge clk) begin
      if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - CNT_W'(1);
   end

   assign done_c = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// LCD bus sequencer: turns CPU register writes into HD44780 setup/enable/hold cycles.
// Optional power-up init sequence enabled by defining LCD_INIT_SEQ_EN.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned INIT_CYC  = 750000,
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned PULSE_CYC = 25,
   parameter int unsigned CMD_CYC   = 2500,
   parameter int unsigned CLR_CYC   = 82000,
   parameter int unsigned CNT_W     = 20
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              lcd_wr_i,
   input  logic [WORD_W-1:0] lcd_word_i,
   output logic              lcd_busy_o,
   output logic              lcd_ovf_o,
   output logic              init_done_o,
   output logic              lcd_on_o,
   output logic              lcd_en_o,
   output logic              lcd_rs_o,
   output logic              lcd_rw_o,
   output logic [DATA_W-1:0] lcd_data_o
);

`ifdef LCD_INIT_SEQ_EN
   localparam bit INIT_EN = 1'b1;
`else
   localparam bit INIT_EN = 1'b0;
`endif

   state_t            state;
   logic              pend_full;
   logic              pend_rs;
   logic [DATA_W-1:0] pend_data;
   logic              init_phase;
   logic [1:0]        init_idx;

   logic              wr_rs;
   logic [DATA_W-1:0] wr_data;
   logic              idle, hold_end, last_init;
   logic              direct, pop, to_pend, drop, pend_full_nx, goes_idle;
   logic              tmr_load, tmr_done_c;
   logic [CNT_W-1:0]  tmr_val;
   logic              unused_word;

   assign wr_rs       = lcd_word_i[RS_BIT];
   assign wr_data     = lcd_word_i[DATA_LSB +: DATA_W];
   assign unused_word = ^lcd_word_i[ON_BIT-1:RS_BIT+1];
   assign lcd_rw_o    = 1'b0;

   // Write routing: straight to the bus when idle, else into the one-deep pending slot
   assign idle         = (state == ST_IDLE);
   assign hold_end     = (state == ST_HOLD) && tmr_done_c;
   assign last_init    = (init_idx == 2'(INIT_N - 1));
   assign pop          = pend_full && (idle || (hold_end && !init_phase));
   assign direct       = lcd_wr_i && idle && !pend_full;
   assign to_pend      = lcd_wr_i && !direct && (!pend_full || pop);
   assign drop         = lcd_wr_i && pend_full && !pop;
   assign pend_full_nx = to_pend || (pend_full && !pop);
   assign goes_idle    = (idle && !direct && !pop)
                       || ((state == ST_PWRUP) && tmr_done_c && !INIT_EN)
                       || (hold_end && !pop && !(init_phase && !last_init));

   // Timer reload at every phase boundary; reset arms the power-up wait
   assign tmr_load = rst_ni || (idle ? (direct || pop) : tmr_done_c);

   // Length of the phase that starts after the current one ends
   always_comb begin
      tmr_val = CNT_W'(SETUP_CYC - 1);
      case (state)
         ST_SETUP: tmr_val = CNT_W'(PULSE_CYC - 1);
         ST_PULSE: tmr_val = is_clear(lcd_rs_o, lcd_data_o) ? CNT_W'(CLR_CYC - 1)
                                                            : CNT_W'(CMD_CYC - 1);
         default:  tmr_val = CNT_W'(SETUP_CYC - 1);
      endcase
      if (rst_ni)
         tmr_val = CNT_W'(INIT_CYC - 1);
   end

   lcd_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk_i),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done_c   (tmr_done_c)
   );

   // Sequencer FSM, pending slot and registered bus/status outputs
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         state       <= ST_PWRUP;
         pend_full   <= 1'b0;
         pend_rs     <= 1'b0;
         pend_data   <= '0;
         init_phase  <= 1'b0;
         init_idx    <= '0;
         lcd_busy_o  <= 1'b0;
         lcd_ovf_o   <= 1'b0;
         init_done_o <= 1'b0;
         lcd_on_o    <= 1'b0;
         lcd_en_o    <= 1'b0;
         lcd_rs_o    <= 1'b0;
         lcd_data_o  <= '0;
      end else begin
         if (lcd_wr_i)
            lcd_on_o <= lcd_word_i[ON_BIT];
         if (drop)
            lcd_ovf_o <= 1'b1;
         if (to_pend) begin
            pend_rs   <= wr_rs;
            pend_data <= wr_data;
         end
         pend_full  <= pend_full_nx;
         lcd_busy_o <= !goes_idle || pend_full_nx;

         case (state)
            ST_PWRUP: begin
               if (tmr_done_c) begin
                  if (INIT_EN) begin
                     init_phase <= 1'b1;
                     init_idx   <= '0;
                     lcd_rs_o   <= 1'b0;
                     lcd_data_o <= init_cmd(2'd0);
                     state      <= ST_SETUP;
                  end else begin
                     init_done_o <= 1'b1;
                     state       <= ST_IDLE;
                  end
               end
            end
            ST_IDLE: begin
               if (direct) begin
                  lcd_rs_o   <= wr_rs;
                  lcd_data_o <= wr_data;
                  state      <= ST_SETUP;
               end else if (pop) begin
                  lcd_rs_o   <= pend_rs;
                  lcd_data_o <= pend_data;
                  state      <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (tmr_done_c) begin
                  lcd_en_o <= 1'b1;
                  state    <= ST_PULSE;
               end
            end
            ST_PULSE: begin
               if (tmr_done_c) begin
                  lcd_en_o <= 1'b0;
                  state    <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (tmr_done_c) begin
                  if (init_phase) begin
                     if (last_init) begin
                        init_phase  <= 1'b0;
                        init_done_o <= 1'b1;
                        state       <= ST_IDLE;
                     end else begin
                        init_idx   <= init_idx + 2'd1;
                        lcd_rs_o   <= 1'b0;
                        lcd_data_o <= init_cmd(init_idx + 2'd1);
                        state      <= ST_SETUP;
                     end
                  end else if (pop) begin
                     lcd_rs_o   <= pend_rs;
                     lcd_data_o <= pend_data;
                     state      <= ST_SETUP;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_PWRUP;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl against a transaction-level timing model.
module tb_lcd_ctrl;

   localparam int INIT = 20;
   localparam int S    = 2;
   localparam int P    = 4;
   localparam int CMD  = 10;
   localparam int CLR  = 30;

`ifdef LCD_INIT_SEQ_EN
   localparam bit INIT_EN = 1'b1;
`else
   localparam bit INIT_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        lcd_wr;
   logic [31:0] lcd_word;
   logic        lcd_busy_o, lcd_ovf_o, init_done_o, lcd_on_o;
   logic        lcd_en_o, lcd_rs_o, lcd_rw_o;
   logic [7:0]  lcd_data_o;

   lcd_ctrl #(
      .INIT_CYC  (INIT),
      .SETUP_CYC (S),
      .PULSE_CYC (P),
      .CMD_CYC   (CMD),
      .CLR_CYC   (CLR),
      .CNT_W     (20)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst),
      .lcd_wr_i    (lcd_wr),
      .lcd_word_i  (lcd_word),
      .lcd_busy_o  (lcd_busy_o),
      .lcd_ovf_o   (lcd_ovf_o),
      .init_done_o (init_done_o),
      .lcd_on_o    (lcd_on_o),
      .lcd_en_o    (lcd_en_o),
      .lcd_rs_o    (lcd_rs_o),
      .lcd_rw_o    (lcd_rw_o),
      .lcd_data_o  (lcd_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: each bus transaction is an interval [start, start+S+P+hold);
   // busy_end is the edge at which the sequencer is done with it.
   int         t, busy_end, cur_start, init_i;
   bit         pwrup, init_act, no_pop, has_txn, pend_v, m_ovf, m_on, m_done;
   logic       cur_rs, pend_rs;
   logic [7:0] cur_data, pend_data;

   function automatic logic [7:0] init_word(input int i);
      case (i)
         0:       return 8'h38;
         1:       return 8'h0C;
         2:       return 8'h01;
         default: return 8'h06;
      endcase
   endfunction

   task automatic model_reset();
      t = 0; busy_end = INIT; cur_start = 0; init_i = 0;
      pwrup = 1; init_act = 0; no_pop = 0; has_txn = 0; pend_v = 0;
      m_ovf = 0; m_on = 0; m_done = 0;
      cur_rs = 0; cur_data = 8'h00; pend_rs = 0; pend_data = 8'h00;
   endtask

   task automatic start_txn(input logic rs, input logic [7:0] d);
      cur_rs = rs; cur_data = d; cur_start = t; has_txn = 1; no_pop = 0;
      busy_end = t + S + P + ((!rs && d >= 8'd1 && d <= 8'd3) ? CLR : CMD);
   endtask

   task automatic model_edge(input logic wr, input logic [31:0] w);
      bit had, free;
      t++;
      if (pwrup && t == busy_end) begin
         pwrup = 0;
         if (INIT_EN) begin
            init_act = 1; init_i = 0;
            start_txn(1'b0, init_word(0));
         end else begin
            m_done = 1; no_pop = 1;
         end
      end else if (init_act && t == busy_end) begin
         if (init_i < 3) begin
            init_i++;
            start_txn(1'b0, init_word(init_i));
         end else begin
            init_act = 0; m_done = 1; no_pop = 1;
         end
      end
      had  = pend_v;
      free = !pwrup && !init_act;
      if (free && pend_v && t >= busy_end + int'(no_pop)) begin
         start_txn(pend_rs, pend_data);
         pend_v = 0;
      end
      if (wr) begin
         m_on = w[31];
         if (free && !had && t > busy_end)
            start_txn(w[8], w[7:0]);
         else if (!pend_v) begin
            pend_v = 1; pend_rs = w[8]; pend_data = w[7:0];
         end else
            m_ovf = 1;
      end
   endtask

   function automatic logic [31:0] model_vec();
      logic en, busy;
      en   = has_txn && (t >= cur_start + S) && (t < cur_start + S + P);
      busy = (t < busy_end) || pend_v;
      return 32'({busy, m_ovf, m_done, m_on, en, cur_rs, 1'b0, cur_data});
   endfunction

   function automatic logic [31:0] dut_vec();
      return 32'({lcd_busy_o, lcd_ovf_o, init_done_o, lcd_on_o,
                  lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o});
   endfunction

   // One clock: present inputs, let the edge happen, compare #1 later
   task automatic cycle(input logic wr, input logic [31:0] w);
      lcd_wr   = wr;
      lcd_word = w;
      @(posedge clk);
      model_edge(wr, w);
      #1;
      check($sformatf("outs t=%0d", t), dut_vec(), model_vec());
      lcd_wr = 1'b0;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      lcd_wr = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         check("reset", dut_vec(), 32'h0);
      end
      rst = 1'b0;
      model_reset();
   endtask

   logic [31:0] rw;

   initial begin
      rst = 1'b1; lcd_wr = 1'b0; lcd_word = 32'h0;
      model_reset();
      do_reset();
      repeat (150) cycle(1'b0, 32'h0);
      check("init_done", 32'(init_done_o), 32'h1);

      // single data write, then a clear command with the ON bit set
      cycle(1'b1, 32'h0000_0141);
      repeat (20) cycle(1'b0, 32'h0);
      cycle(1'b1, 32'h8000_0001);
      repeat (40) cycle(1'b0, 32'h0);
      check("on_after_clr", 32'(lcd_on_o), 32'h1);

      // back-to-back: active, pending, dropped
      cycle(1'b1, 32'h0000_0141);
      cycle(1'b1, 32'h0000_0142);
      cycle(1'b1, 32'h0000_0143);
      check("ovf_b2b", 32'(lcd_ovf_o), 32'h1);
      repeat (40) cycle(1'b0, 32'h0);

      // reset while EN is high with a word pending
      cycle(1'b1, 32'h0000_0141);
      cycle(1'b1, 32'h0000_0142);
      cycle(1'b0, 32'h0);
      check("en_before_rst", 32'(lcd_en_o), 32'h1);
      do_reset();
      check("ovf_after_rst", 32'(lcd_ovf_o), 32'h0);

      // write during power-up (and init when enabled) runs afterwards
      repeat (5) cycle(1'b0, 32'h0);
      cycle(1'b1, 32'h8000_0155);
      repeat (150) cycle(1'b0, 32'h0);

      // random traffic, biased towards clear/home commands
      for (int i = 0; i < 1500; i++) begin
         if (i == 750) do_reset();
         rw = $urandom;
         if ($urandom_range(0, 2) == 0) begin
            rw[8]   = 1'b0;
            rw[7:0] = 8'($urandom_range(1, 3));
         end
         cycle($urandom_range(0, 5) == 0, rw);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
